square_fixed_point: RTL

Sequential unsigned fixed-point squarer, the inverse companion of the fixed-point square-root block in the DSP filter library. It accepts one Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS operand over a valid/ready handshake and computes x² with a shift-add engine, one multiplier bit per cycle. It returns the result in the same Q format, saturated, with an overflow flag. It sits in the magnitude/energy path, where it re-squares square-root outputs and computes power terms.

---
 rtl/square_fixed_point.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/square_fixed_point.sv
// Sequential unsigned Q-format squarer (shift-add, one multiplier bit per cycle) with saturation.
// Latency DATA_WIDTH+1 cycles from acceptance to o_valid; result held until i_ready, o_ready only in IDLE.
// Optional SQUARE_FIXED_POINT_ROUND_EN: round-half-up on scaling instead of truncation.
module square_fixed_point #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overflow
);

    localparam int ACC_W = 2 * DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef SQUARE_FIXED_POINT_ROUND_EN
    localparam logic [ACC_W-1:0] ONE_ACC   = 1;
    localparam logic [ACC_W-1:0] ROUND_ADD =
        (FRAC_BITS > 0) ? (ONE_ACC << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NORM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mult_q, mult_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    ovf_q, ovf_d;

    logic [ACC_W-1:0]        rnd_sum;
    logic [ACC_W-1:0]        scaled;
    logic                    sat;

    always_comb begin
`ifdef SQUARE_FIXED_POINT_ROUND_EN
        rnd_sum = acc_q + ROUND_ADD;
`else
        rnd_sum = acc_q;
`endif
        scaled = rnd_sum >> FRAC_BITS;
        sat    = |scaled[ACC_W-1:DATA_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ready_d = ready_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    mcand_d = {{(ACC_W - DATA_WIDTH){1'b0}}, i_data};
                    mult_d  = i_data;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DATA_WIDTH);
                    ready_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // mcand_q carries the shift by the iteration index
                acc_d   = acc_q + (mult_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                data_d  = sat ? '1 : scaled[DATA_WIDTH-1:0];
                ovf_d   = sat;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_overflow = ovf_q;

endmodule
